// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 Set-2 constants, discard codes and decoder state enum
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Keyboard status/ack bytes that never carry key information.
  localparam logic [7:0] PS2_DISCARD_ERR0 = 8'h00;
  localparam logic [7:0] PS2_DISCARD_BAT  = 8'hAA;
  localparam logic [7:0] PS2_DISCARD_ACK  = 8'hFA;
  localparam logic [7:0] PS2_DISCARD_RSND = 8'hFE;
  localparam logic [7:0] PS2_DISCARD_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } ps2_state_t;

  function automatic logic ps2_is_discard(input logic [7:0] b);
    return (b == PS2_DISCARD_ERR0) || (b == PS2_DISCARD_BAT) ||
           (b == PS2_DISCARD_ACK)  || (b == PS2_DISCARD_RSND) ||
           (b == PS2_DISCARD_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - merges F0/E0 prefixes into key events; PS2_KEY_EVENT_REPEAT_EN reports repeats
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           ps2_data,
  input  logic                 ps2_ready,
  output logic                 nextdata_n,
  output logic [7:0]           key_code,
  output logic                 key_ext,
  output logic                 key_held,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic                 evt_valid,
  output logic [7:0]           evt_code,
  output logic                 evt_break,
`ifdef PS2_KEY_EVENT_REPEAT_EN
  output logic                 evt_repeat,
`endif
  output logic                 evt_ext
);

  ps2_state_t state;
  logic [7:0] byte_q;
  logic       brk_pend;
  logic       ext_pend;
  logic       key_match;

  assign key_match = key_held && (byte_q == key_code) && (ext_pend == key_ext);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= S_IDLE;
      byte_q     <= 8'h00;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      nextdata_n <= 1'b1;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_held   <= 1'b0;
      press_cnt  <= '0;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_break  <= 1'b0;
      evt_ext    <= 1'b0;
`ifdef PS2_KEY_EVENT_REPEAT_EN
      evt_repeat <= 1'b0;
`endif
    end else begin
      evt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          nextdata_n <= 1'b1;
          if (ps2_ready) begin
            byte_q     <= ps2_data;
            nextdata_n <= 1'b0;
            state      <= S_POP;
          end
        end
        S_POP: begin
          nextdata_n <= 1'b1;
          state      <= S_GAP;
          if (byte_q == PS2_BREAK) begin
            brk_pend <= 1'b1;
          end else if (byte_q == PS2_EXT) begin
            ext_pend <= 1'b1;
          end else begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
            if (ps2_is_discard(byte_q)) begin
              // status byte: prefixes seen before it are stale
            end else if (brk_pend) begin
              evt_valid <= 1'b1;
              evt_break <= 1'b1;
              evt_code  <= byte_q;
              evt_ext   <= ext_pend;
`ifdef PS2_KEY_EVENT_REPEAT_EN
              evt_repeat <= 1'b0;
`endif
              if (key_match) key_held <= 1'b0;
            end else if (key_match) begin
              // typematic repeat of the held key: never counted
`ifdef PS2_KEY_EVENT_REPEAT_EN
              evt_valid  <= 1'b1;
              evt_break  <= 1'b0;
              evt_code   <= byte_q;
              evt_ext    <= ext_pend;
              evt_repeat <= 1'b1;
`endif
            end else begin
              key_code  <= byte_q;
              key_ext   <= ext_pend;
              key_held  <= 1'b1;
              press_cnt <= press_cnt + CNT_WIDTH'(1);
              evt_valid <= 1'b1;
              evt_break <= 1'b0;
              evt_code  <= byte_q;
              evt_ext   <= ext_pend;
`ifdef PS2_KEY_EVENT_REPEAT_EN
              evt_repeat <= 1'b0;
`endif
            end
          end
        end
        S_GAP: begin
          // one idle cycle lets the receiver FIFO pointer and ready settle
          nextdata_n <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          nextdata_n <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// tb/tb_ps2_key_event.sv - scoreboard bench for ps2_key_event with a modelled receiver FIFO
module tb_ps2_key_event;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       rep;
  } evt_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_cnt;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       evt_repeat;

  int total = 0;
  int bad = 0;

  logic [7:0] fifo_q[$];
  evt_t       exp_q[$];

  always #5 clk = ~clk;

  ps2_key_event #(.CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_data   (ps2_data),
    .ps2_ready  (ps2_ready),
    .nextdata_n (nextdata_n),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_held   (key_held),
    .press_cnt  (press_cnt),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_break  (evt_break),
`ifdef PS2_KEY_EVENT_REPEAT_EN
    .evt_repeat (evt_repeat),
`endif
    .evt_ext    (evt_ext)
  );

`ifndef PS2_KEY_EVENT_REPEAT_EN
  assign evt_repeat = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Receiver model: the head pops on a low nextdata_n, ready follows occupancy.
  always @(negedge clk) begin
    if (nextdata_n == 1'b0 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ps2_ready = (fifo_q.size() > 0);
    ps2_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  logic prev_low = 1'b0;
  logic prev_evt = 1'b0;
  logic seen_pop = 1'b0;
  int   gap = 0;

  always @(negedge clk) begin
    if (rstn) begin
      prev_low = 1'b0;
      prev_evt = 1'b0;
    end else begin
      if (nextdata_n == 1'b0) begin
        check("pop_width", {31'd0, prev_low}, 32'd0);
        if (seen_pop) check("pop_spacing", {31'd0, (gap >= 2)}, 32'd1);
        seen_pop = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
      prev_low = (nextdata_n == 1'b0);
      if (evt_valid) begin
        evt_t e;
        check("evt_b2b", {31'd0, prev_evt}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL evt_unexpected: got code=%0h brk=%0b ext=%0b want none",
                   evt_code, evt_break, evt_ext);
        end else begin
          e = exp_q.pop_front();
          check("evt_code", {24'd0, evt_code}, {24'd0, e.code});
          check("evt_break", {31'd0, evt_break}, {31'd0, e.brk});
          check("evt_ext", {31'd0, evt_ext}, {31'd0, e.ext});
`ifdef PS2_KEY_EVENT_REPEAT_EN
          check("evt_repeat", {31'd0, evt_repeat}, {31'd0, e.rep});
`endif
        end
      end
      prev_evt = evt_valid;
    end
  end

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic exp_evt(input logic [7:0] code, input logic brk, input logic ext, input logic rep);
    evt_t e;
    e.code = code;
    e.brk  = brk;
    e.ext  = ext;
    e.rep  = rep;
    exp_q.push_back(e);
  endtask

  task automatic make(input logic [7:0] code, input logic ext);
    if (ext) send(8'hE0);
    send(code);
    exp_evt(code, 1'b0, ext, 1'b0);
  endtask

  task automatic release_key(input logic [7:0] code, input logic ext);
    if (ext) send(8'hE0);
    send(8'hF0);
    send(code);
    exp_evt(code, 1'b1, ext, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((fifo_q.size() > 0 || ps2_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d bytes left want 0", name, fifo_q.size());
      fifo_q.delete();
    end
    repeat (4) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] c;

    repeat (3) @(negedge clk);
    check("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("rst_outputs", {8'd0, key_code, press_cnt, key_ext, key_held, evt_valid,
                          evt_break, evt_ext, evt_repeat, 2'b00}, 32'd0);
    check("rst_evt_code", {24'd0, evt_code}, 32'd0);
    rstn = 1'b0;

    // make, then release
    make(8'h1C, 1'b0);
    wait_idle("t1_make");
    check("t1_held", {31'd0, key_held}, 32'd1);
    check("t1_code", {24'd0, key_code}, 32'h1C);
    check("t1_cnt", {24'd0, press_cnt}, 32'd1);
    release_key(8'h1C, 1'b0);
    wait_idle("t1_rel");
    check("t1_released", {31'd0, key_held}, 32'd0);

    // typematic repeats
    make(8'h1C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'h1C);
`ifdef PS2_KEY_EVENT_REPEAT_EN
      exp_evt(8'h1C, 1'b0, 1'b0, 1'b1);
`endif
    end
    wait_idle("t2_rep");
    check("t2_cnt", {24'd0, press_cnt}, 32'd2);
    check("t2_held", {31'd0, key_held}, 32'd1);
    release_key(8'h1C, 1'b0);
    wait_idle("t2_rel");
    check("t2_released", {31'd0, key_held}, 32'd0);

    // rollover: second make replaces the tracked key
    make(8'h1C, 1'b0);
    make(8'h32, 1'b0);
    wait_idle("t3_roll");
    check("t3_code", {24'd0, key_code}, 32'h32);
    check("t3_cnt", {24'd0, press_cnt}, 32'd4);
    release_key(8'h1C, 1'b0);
    wait_idle("t3_rel_other");
    check("t3_still_held", {31'd0, key_held}, 32'd1);
    release_key(8'h32, 1'b0);
    wait_idle("t3_rel");
    check("t3_released", {31'd0, key_held}, 32'd0);

    // extended keys, both prefix orders
    make(8'h75, 1'b1);
    wait_idle("t4_ext");
    check("t4_key_ext", {31'd0, key_ext}, 32'd1);
    check("t4_cnt", {24'd0, press_cnt}, 32'd5);
    release_key(8'h75, 1'b1);
    wait_idle("t4_ext_rel");
    check("t4_released", {31'd0, key_held}, 32'd0);
    make(8'h75, 1'b0);
    wait_idle("t4_plain");
    check("t4_plain_ext", {31'd0, key_ext}, 32'd0);
    release_key(8'h75, 1'b0);
    make(8'h75, 1'b1);
    send(8'hF0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    exp_evt(8'h75, 1'b1, 1'b1, 1'b0);
    wait_idle("t4_fe");
    check("t4_fe_released", {31'd0, key_held}, 32'd0);
    check("t4_fe_cnt", {24'd0, press_cnt}, 32'd7);

    // discard bytes clear pending prefixes
    send(8'hAA);
    send(8'hFA);
    send(8'hF0);
    send(8'hFA);
    make(8'h16, 1'b0);
    wait_idle("t5_disc");
    check("t5_held", {31'd0, key_held}, 32'd1);
    check("t5_cnt", {24'd0, press_cnt}, 32'd8);
    release_key(8'h16, 1'b0);
    wait_idle("t5_rel");

    // reset while popping the break prefix
    send(8'hF0);
    n = 0;
    while (nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_pop", {31'd0, nextdata_n}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("t6_outputs", {8'd0, key_code, press_cnt, key_ext, key_held, evt_valid,
                         evt_break, evt_ext, evt_repeat, 2'b00}, 32'd0);
    rstn = 1'b0;
    fifo_q.delete();
    make(8'h1C, 1'b0);
    wait_idle("t6_make");
    check("t6_cnt", {24'd0, press_cnt}, 32'd1);
    check("t6_held", {31'd0, key_held}, 32'd1);

    // counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      c = 8'h01 + 8'(i % 112);
      make(c, 1'b0);
      release_key(c, 1'b0);
    end
    wait_idle("t7_fill");
    check("t7_cnt_255", {24'd0, press_cnt}, 32'd255);
    make(8'h16, 1'b0);
    wait_idle("t7_wrap");
    check("t7_cnt_wrap", {24'd0, press_cnt}, 32'd0);
    check("t7_held", {31'd0, key_held}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
